// File: rtl/dff_bank_activity_monitor.sv
// Activity monitor for a DFFASX1 flop bank. Counts total and rising
// transitions of Q_IN over a programmable window, flags any Q/QN bit pair
// that is not complementary, and hands each window's result to the
// power-log collector over a valid/ready handshake.
module dff_bank_activity_monitor #(
  parameter int N     = 8,
  parameter int CNT_W = 24,
  parameter int WIN_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIN_W-1:0] WIN_LEN,
  input  logic [N-1:0]     Q_IN,
  input  logic [N-1:0]     QN_IN,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [CNT_W-1:0] RES_TOGGLES,
  output logic [CNT_W-1:0] RES_RISES,
  output logic             RES_OVF,
  output logic             RES_DROP,
  output logic             COMPL_ERR
);

  localparam int PW = $clog2(N + 1);
  // Sum width is wide enough for either operand plus a carry bit.
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  typedef enum logic {IDLE, COUNT} state_t;

  function automatic logic [PW-1:0] popcnt(input logic [N-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  // Returns {saturated, clamped_sum}.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                             input logic [PW-1:0]    b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s > SW'(ACC_MAX)) return {1'b1, ACC_MAX};
    return {1'b0, s[CNT_W-1:0]};
  endfunction

  state_t             state_q, state_d;
  logic [N-1:0]       prev_q, prev_d;
  logic [WIN_W-1:0]   win_len_q, win_len_d;
  logic [WIN_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   tog_acc_q, tog_acc_d;
  logic [CNT_W-1:0]   rise_acc_q, rise_acc_d;
  logic               ovf_q, ovf_d;
  logic               drop_pend_q, drop_pend_d;
  logic               res_valid_q, res_valid_d;
  logic [CNT_W-1:0]   res_tog_q, res_tog_d;
  logic [CNT_W-1:0]   res_rise_q, res_rise_d;
  logic               res_ovf_q, res_ovf_d;
  logic               res_drop_q, res_drop_d;
  logic               compl_err_q, compl_err_d;

  logic [CNT_W:0]     tog_sum, rise_sum;
  logic [WIN_W:0]     cyc_inc;
  logic [WIN_W-1:0]   win_len_sel;
  logic               win_ovf;
  logic               publish;

  // Next-state: window sequencing, accumulation, publish/drop and sticky error.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    win_len_d   = win_len_q;
    cyc_d       = cyc_q;
    tog_acc_d   = tog_acc_q;
    rise_acc_d  = rise_acc_q;
    ovf_d       = ovf_q;
    drop_pend_d = drop_pend_q;
    res_valid_d = res_valid_q;
    res_tog_d   = res_tog_q;
    res_rise_d  = res_rise_q;
    res_ovf_d   = res_ovf_q;
    res_drop_d  = res_drop_q;
    publish     = 1'b0;

    tog_sum     = sat_add(tog_acc_q, popcnt(Q_IN ^ prev_q));
    rise_sum    = sat_add(rise_acc_q, popcnt(Q_IN & ~prev_q));
    win_ovf     = ovf_q | tog_sum[CNT_W] | rise_sum[CNT_W];
    cyc_inc     = {1'b0, cyc_q} + 1'b1;
    win_len_sel = (WIN_LEN == '0) ? WIN_W'(1) : WIN_LEN;

    // Every enabled cycle is a sampling cycle, baseline or counting.
    compl_err_d = compl_err_q | (EN & ~&(Q_IN ^ QN_IN));

    if (res_valid_q && RES_READY) res_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (EN) begin
          // Baseline capture: contributes no transitions.
          state_d    = COUNT;
          prev_d     = Q_IN;
          win_len_d  = win_len_sel;
          cyc_d      = '0;
          tog_acc_d  = '0;
          rise_acc_d = '0;
          ovf_d      = 1'b0;
        end
      end
      COUNT: begin
        if (!EN) begin
          // Partial window is abandoned; re-enable takes a new baseline.
          state_d = IDLE;
        end else begin
          prev_d = Q_IN;
          if (cyc_inc == {1'b0, win_len_q}) begin
            // Last sample of the window: publish and roll straight into the next.
            publish    = 1'b1;
            tog_acc_d  = '0;
            rise_acc_d = '0;
            ovf_d      = 1'b0;
            cyc_d      = '0;
            win_len_d  = win_len_sel;
          end else begin
            tog_acc_d  = tog_sum[CNT_W-1:0];
            rise_acc_d = rise_sum[CNT_W-1:0];
            ovf_d      = win_ovf;
            cyc_d      = cyc_inc[WIN_W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (publish) begin
      if (!res_valid_q || RES_READY) begin
        res_valid_d = 1'b1;
        res_tog_d   = tog_sum[CNT_W-1:0];
        res_rise_d  = rise_sum[CNT_W-1:0];
        res_ovf_d   = win_ovf;
        res_drop_d  = drop_pend_q;
        drop_pend_d = 1'b0;
      end else begin
        // Collector stalled: hold the old result, remember the loss.
        drop_pend_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      win_len_q   <= '0;
      cyc_q       <= '0;
      tog_acc_q   <= '0;
      rise_acc_q  <= '0;
      ovf_q       <= 1'b0;
      drop_pend_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_tog_q   <= '0;
      res_rise_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_drop_q  <= 1'b0;
      compl_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      win_len_q   <= win_len_d;
      cyc_q       <= cyc_d;
      tog_acc_q   <= tog_acc_d;
      rise_acc_q  <= rise_acc_d;
      ovf_q       <= ovf_d;
      drop_pend_q <= drop_pend_d;
      res_valid_q <= res_valid_d;
      res_tog_q   <= res_tog_d;
      res_rise_q  <= res_rise_d;
      res_ovf_q   <= res_ovf_d;
      res_drop_q  <= res_drop_d;
      compl_err_q <= compl_err_d;
    end
  end

  assign RES_VALID   = res_valid_q;
  assign RES_TOGGLES = res_tog_q;
  assign RES_RISES   = res_rise_q;
  assign RES_OVF     = res_ovf_q;
  assign RES_DROP    = res_drop_q;
  assign COMPL_ERR   = compl_err_q;

endmodule

// File: tb/tb_dff_bank_activity_monitor.sv
// Scoreboard bench: a window-level reference model pushes each result the
// collector should see; a negedge monitor compares what the DUT presents.
module tb_dff_bank_activity_monitor;

  localparam int N     = 8;
  localparam int CNT_W = 5;   // small so saturation is reachable
  localparam int WIN_W = 16;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic [N-1:0]     q_in = '0;
  logic [N-1:0]     qn_in = '1;
  logic             rdy = 1'b0;
  logic             res_valid;
  logic [CNT_W-1:0] res_tog;
  logic [CNT_W-1:0] res_rise;
  logic             res_ovf;
  logic             res_drop;
  logic             compl_err;

  int total = 0;
  int bad   = 0;

  dff_bank_activity_monitor #(.N(N), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .CLK(clk), .RST(rst), .EN(en), .WIN_LEN(win_len), .Q_IN(q_in), .QN_IN(qn_in),
    .RES_VALID(res_valid), .RES_READY(rdy), .RES_TOGGLES(res_tog),
    .RES_RISES(res_rise), .RES_OVF(res_ovf), .RES_DROP(res_drop),
    .COMPL_ERR(compl_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int tg;
    int rs;
    bit ovf;
    bit drop;
  } res_t;

  res_t     exp_q[$];
  bit       m_active = 0;
  bit       m_valid  = 0;
  bit       m_drop_p = 0;
  bit       m_err    = 0;
  bit       m_zero   = 1;
  bit [N-1:0] m_prev = '0;
  int       m_wl = 1, m_n = 0, m_tg = 0, m_rs = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_valid = 0; m_drop_p = 0; m_err = 0; m_zero = 1;
      exp_q.delete();
    end else begin
      bit xfer, pub;
      res_t r;
      xfer = m_valid && rdy;
      pub  = 0;
      if (en && ((q_in ^ qn_in) != {N{1'b1}})) m_err = 1;
      if (!en) begin
        m_active = 0;
      end else if (!m_active) begin
        m_active = 1; m_prev = q_in; m_n = 0; m_tg = 0; m_rs = 0;
        m_wl = (win_len == 0) ? 1 : int'(win_len);
      end else begin
        m_tg += $countones(q_in ^ m_prev);
        m_rs += $countones(q_in & ~m_prev);
        m_prev = q_in;
        m_n++;
        if (m_n == m_wl) begin
          pub   = 1;
          r.tg  = (m_tg > MAXV) ? MAXV : m_tg;
          r.rs  = (m_rs > MAXV) ? MAXV : m_rs;
          r.ovf = (m_tg > MAXV) || (m_rs > MAXV);
          m_n = 0; m_tg = 0; m_rs = 0;
          m_wl = (win_len == 0) ? 1 : int'(win_len);
        end
      end
      if (pub) begin
        if (!m_valid || xfer) begin
          r.drop = m_drop_p;
          exp_q.push_back(r);
          m_valid = 1; m_drop_p = 0; m_zero = 0;
        end else begin
          m_drop_p = 1;
        end
      end else if (xfer) begin
        m_valid = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    chk("res_valid", res_valid, m_valid);
    chk("compl_err", compl_err, m_err);
    if (m_zero) begin
      chk("rst_toggles", res_tog, 0);
      chk("rst_rises", res_rise, 0);
      chk("rst_ovf", res_ovf, 0);
      chk("rst_drop", res_drop, 0);
    end
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        chk("sb_toggles", res_tog, exp_q[0].tg);
        chk("sb_rises", res_rise, exp_q[0].rs);
        chk("sb_ovf", res_ovf, exp_q[0].ovf);
        chk("sb_drop", res_drop, exp_q[0].drop);
        if (rdy) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setq(input logic [N-1:0] v);
    q_in  = v;
    qn_in = ~v;
  endtask

  initial begin
    rst = 1; tick(); tick();
    chk("reset_valid", res_valid, 0);
    chk("reset_err", compl_err, 0);
    chk("reset_tog", res_tog, 0);
    rst = 0;

    // Basic window of 4 samples.
    en = 1; win_len = 4; rdy = 1; setq(8'h00); tick();
    setq(8'hFF); tick();
    setq(8'h00); tick();
    setq(8'hFF); tick();
    setq(8'h0F); tick();
    chk("t1_valid", res_valid, 1);
    chk("t1_toggles", res_tog, 28);
    chk("t1_rises", res_rise, 16);
    chk("t1_ovf", res_ovf, 0);
    chk("t1_drop", res_drop, 0);
    en = 0; tick();

    // Stalled collector: two windows dropped, flagged on the next publish.
    en = 1; win_len = 2; rdy = 0; setq(8'hA5); tick();
    for (int i = 0; i < 6; i++) tick();
    chk("t2_held_valid", res_valid, 1);
    chk("t2_held_tog", res_tog, 0);
    rdy = 1; tick();
    chk("t2_accept_valid", res_valid, 0);
    tick();
    chk("t2_drop_set", res_drop, 1);
    tick(); tick();
    chk("t2_drop_clr", res_drop, 0);
    en = 0; tick();

    // Saturation then a clean window.
    en = 1; win_len = 4; setq(8'h00); tick();
    setq(8'hFF); tick(); setq(8'h00); tick(); setq(8'hFF); tick(); setq(8'h00); tick();
    chk("t3_sat_tog", res_tog, MAXV);
    chk("t3_sat_ovf", res_ovf, 1);
    chk("t3_sat_rise", res_rise, 16);
    setq(8'hFF); tick(); setq(8'h00); tick(); setq(8'hFF); tick(); setq(8'hFF); tick();
    chk("t3_next_ovf", res_ovf, 0);
    chk("t3_next_tog", res_tog, 24);

    // Non-complement pair mid-window.
    setq(8'h01); tick();
    q_in = 8'h01; qn_in = 8'hFF; tick();
    chk("t4_err", compl_err, 1);
    setq(8'h01); tick(); setq(8'h00); tick(); tick();
    chk("t4_err_sticky", compl_err, 1);

    // Reset mid-window discards the partial window.
    en = 0; tick();
    en = 1; win_len = 8; setq(8'h00); tick();
    setq(8'h3C); tick(); setq(8'hC3); tick();
    rst = 1; tick();
    chk("t5_valid", res_valid, 0);
    chk("t5_err", compl_err, 0);
    chk("t5_tog", res_tog, 0);
    rst = 0;
    for (int i = 0; i < 10; i++) begin setq(8'(i * 37)); tick(); end

    // WIN_LEN=0 behaves as one-sample windows.
    en = 0; tick();
    en = 1; win_len = 0; setq(8'h00); tick();
    for (int i = 0; i < 6; i++) begin
      setq((i % 2 == 0) ? 8'h01 : 8'h00); tick();
      chk("t6_valid", res_valid, 1);
      chk("t6_tog", res_tog, 1);
    end
    en = 0; tick(); tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      en      = ($urandom_range(0, 19) != 0);
      win_len = WIN_W'($urandom_range(0, 6));
      rdy     = ($urandom_range(0, 2) != 0);
      q_in    = N'($urandom);
      qn_in   = ($urandom_range(0, 99) == 0) ? N'($urandom) : ~q_in;
      tick();
    end

    // Drain.
    rst = 0; en = 0; rdy = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("final_valid", res_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
